// File: rtl/rx_cfg_ctrl.sv
// Receive-configuration controller: host-written shadow config, committed to the
// live vector only between frames. Optional watchdog guarded by RX_CFG_WATCHDOG_EN.
module rx_cfg_ctrl #(
    parameter logic [15:0] MAX_FRAME_WORDS = 16'd1200,
    parameter logic [52:0] CFG_RESET       = 53'h0
) (
    input  logic        rxclk_in,
    input  logic        reset_n_in,
    input  logic [63:0] rxd64_in,
    input  logic [7:0]  rxc8_in,
    input  logic        host_wr_en,
    input  logic        host_addr,
    input  logic [31:0] host_wr_data,
    output logic        host_wr_ack,
    output logic [31:0] host_rd_data,
    output logic [52:0] cfgRxRegData_out,
    output logic        cfg_pending,
    output logic        in_frame,
    output logic        frame_timeout
);

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t      state_q, state_d;
    logic [52:0] shadow_q, shadow_d;
    logic [52:0] live_q, live_d;
    logic        pending_q, pending_d;
    logic        ack_q;
    logic        commit;
    logic        start;
    logic        term;
    logic [7:0]  term_lane;

    assign start = rxc8_in[7] && (rxd64_in[63:56] == 8'hFB);

    for (genvar gi = 0; gi < 8; gi++) begin : g_term
        assign term_lane[gi] = rxc8_in[gi] && (rxd64_in[gi*8 +: 8] == 8'hFD);
    end
    assign term = |term_lane;

`ifdef RX_CFG_WATCHDOG_EN
    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;
`else
    logic        wd_param_unused;
    assign wd_param_unused = ^MAX_FRAME_WORDS;
`endif

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        live_d    = live_q;
        pending_d = pending_q;
        commit    = 1'b0;
`ifdef RX_CFG_WATCHDOG_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FRAME;
`ifdef RX_CFG_WATCHDOG_EN
                    cnt_d   = 16'd0;
`endif
                end else if (pending_q) begin
                    commit = 1'b1;
                end
            end
            FRAME: begin
                if (term) begin
                    state_d = GAP;
`ifdef RX_CFG_WATCHDOG_EN
                end else if (cnt_q == MAX_FRAME_WORDS - 16'd1) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    commit    = pending_q;
                end else if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
`endif
                end
            end
            GAP: begin
                if (start) begin
                    state_d = FRAME;
`ifdef RX_CFG_WATCHDOG_EN
                    cnt_d   = 16'd0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Commit samples the pre-write shadow; a same-edge write keeps pending set.
        if (commit) begin
            live_d    = shadow_q;
            pending_d = 1'b0;
        end
        if (host_wr_en) begin
            if (host_addr) shadow_d[52:32] = host_wr_data[20:0];
            else           shadow_d[31:0]  = host_wr_data;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge rxclk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q   <= IDLE;
            shadow_q  <= CFG_RESET;
            live_q    <= CFG_RESET;
            pending_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            live_q    <= live_d;
            pending_q <= pending_d;
            ack_q     <= host_wr_en;
        end
    end

`ifdef RX_CFG_WATCHDOG_EN
    always_ff @(posedge rxclk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
    assign frame_timeout = timeout_q;
`else
    assign frame_timeout = 1'b0;
`endif

    assign host_wr_ack      = ack_q;
    assign host_rd_data     = host_addr ? {11'd0, shadow_q[52:32]} : shadow_q[31:0];
    assign cfgRxRegData_out = live_q;
    assign cfg_pending      = pending_q;
    assign in_frame         = (state_q == FRAME);

endmodule
